kbd_mem_arbiter: RTL and testbench
==================================

Name: kbd_mem_arbiter

Overview:
- Shares the single memory port (15-bit address, 16-bit write data, write enable) between the Core and the keyboard character stream from IO_Module.
- Characters are queued in a small FIFO and written one per granted slot into a circular text buffer in memory.
- Core has default ownership; keyboard writes steal single cycles, with a bounded-wait rule so a busy core cannot starve the keyboard.
- Sits between Core/IO_Module and the memory port, replacing the fixed core/dispatch mux in the top level.

Parameters:
- BUF_BASE, 15'h0605, first address of the text buffer.
- BUF_END, 15'h23FF, last address of the text buffer (inclusive).
- FIFO_DEPTH, 4, character FIFO entries (power of two, at least 2).
- MAX_WAIT, 8, maximum consecutive cycles a non-empty FIFO waits while the core holds the port.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- core_req  in  1  core wants the memory port this cycle.
- core_addr  in  15  core address.
- core_wdata  in  16  core write data.
- core_we  in  1  core write enable.
- core_gnt  out  1  core owns the port this cycle; core must hold its request while this is 0.
- io_char  in  8  character from IO_Module.
- io_char_valid  in  1  one-cycle strobe, io_char valid.
- mem_addr  out  15  memory address.
- mem_wdata  out  16  memory write data.
- mem_we  out  1  memory write enable.
- wr_ptr  out  15  next text-buffer write address.
- fifo_full  out  1  FIFO holds FIFO_DEPTH entries.
- overflow  out  1  sticky: a character was dropped.
- enter_pulse  out  1  one-cycle pulse when 8'h0D is written to memory.

Behaviour:
- Reset (rst_n low, asynchronous): state S_CORE; wr_ptr=BUF_BASE; FIFO empty; wait_cnt=0; overflow=0; enter_pulse=0; mem_we forced to 0 while rst_n is low.
- Two-state FSM.
  - S_CORE:
    - Outputs: core_gnt=1; mem_addr=core_addr; mem_wdata=core_wdata; mem_we=core_we&core_req.
    - Go to S_IO next cycle if the FIFO is non-empty AND (core_req=0 OR wait_cnt==MAX_WAIT-1 OR fifo_full=1).
  - S_IO:
    - Outputs: core_gnt=0; mem_addr=wr_ptr; mem_wdata={8'h00, FIFO head}; mem_we=1.
    - Pop the FIFO and advance wr_ptr.
    - Always return to S_CORE next cycle (exactly one keyboard write per grant).
- wait_cnt:
  - Increments each S_CORE cycle with core_req=1 and the FIFO non-empty.
  - Clears on entry to S_IO or when the FIFO is empty.
  - Saturates at MAX_WAIT-1.
- Latency:
  - A character strobed into an empty FIFO with core idle is written 2 cycles later: push at edge N, state S_IO after edge N+1, write at edge N+2.
  - Worst case with a busy core: MAX_WAIT+1 cycles after reaching the FIFO head.
- FIFO rules:
  - Push on io_char_valid when not full.
  - Push when full with no pop that cycle: drop the character and set overflow (cleared only by reset).
  - Push and pop in the same cycle: both happen, count unchanged, and push is accepted even when full.
- wr_ptr wrap: after writing at BUF_END, wr_ptr becomes BUF_BASE. Otherwise wr_ptr increments by 15'd1.
- enter_pulse is high in the same cycle as the S_IO write whose head character is 8'h0D. The character is still written.
- fifo_full, wr_ptr and overflow are registered outputs. core_gnt and the mem_* outputs are combinational from state and the registered FIFO head.
- Core stalled mid-request: the core's address, data and write are ignored during S_IO. The core re-presents them next cycle; the arbiter does not capture them.

Decomposition:
- Shared package kbd_pkg:
  - state enum {S_CORE, S_IO};
  - CHAR_ENTER=8'h0D;
  - default BUF_BASE and BUF_END constants, shared with the display and dispatch logic.
- One sub-module, char_fifo (parameter DEPTH, 8-bit data):
  - ports clk, rst_n, push, din, pop, dout, empty, full, with simultaneous push/pop supported when full.
- FSM, wait counter and wr_ptr live in kbd_mem_arbiter.

Test Plan:
- Reset mid-operation: assert rst_n low during S_IO with 2 chars queued -> mem_we=0 immediately, wr_ptr=15'h0605, fifo empty, overflow=0; after release, core_gnt=1.
- Core idle, strobe 8'h41 -> write to 15'h0605 with data 16'h0041, two edges after the strobe; wr_ptr=15'h0606; core_gnt low only during that cycle.
- Core requests every cycle, one char queued -> core_gnt stays 1 for exactly 8 cycles, then 1 cycle of 0 with the keyboard write; FIFO then empty.
- Core busy, strobe 6 chars on consecutive cycles with depth 4:
  - fifo_full forces a steal cycle;
  - overflow=1;
  - the written chars are exactly those accepted, in order, with no duplicates.
- Preload wr_ptr to 15'h23FF by writing 7674 chars (or a forced initial value), strobe 2 chars -> writes at 15'h23FF then 15'h0605.
- Strobe 8'h0D -> memory gets 16'h000D and enter_pulse is high for exactly that one cycle.

Source files
------------

// File: rtl/kbd_pkg.sv
// Shared keyboard/text-buffer definitions: arbiter FSM states, the
// carriage-return code and default text buffer bounds.
package kbd_pkg;

    typedef enum logic {
        S_CORE = 1'b0,
        S_IO   = 1'b1
    } state_e;

    localparam logic [7:0]  CHAR_ENTER   = 8'h0D;
    localparam logic [14:0] DEF_BUF_BASE = 15'h0605;
    localparam logic [14:0] DEF_BUF_END  = 15'h23FF;

    // Next circular text-buffer address.
    function automatic logic [14:0] buf_next(
        input logic [14:0] p,
        input logic [14:0] base,
        input logic [14:0] last
    );
        return (p == last) ? base : p + 15'd1;
    endfunction

endpackage

// File: rtl/kbd_mem_arbiter_if.sv
// Memory-port bundle: core request side plus the shared memory port.
// master = core/memory side, slave = arbiter.
interface kbd_mem_arbiter_if;

    logic        core_req;
    logic [14:0] core_addr;
    logic [15:0] core_wdata;
    logic        core_we;
    logic        core_gnt;
    logic [14:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;

    modport master (
        output core_req, core_addr, core_wdata, core_we,
        input  core_gnt, mem_addr, mem_wdata, mem_we
    );

    modport slave (
        input  core_req, core_addr, core_wdata, core_we,
        output core_gnt, mem_addr, mem_wdata, mem_we
    );

endinterface

// File: rtl/kbd_mem_arbiter_fifo.sv
// char_fifo: 8-bit character FIFO, DEPTH a power of two.
// Ports: clk, rst_n, push/din, pop/dout, empty, full (registered).
module char_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] dout,
    output logic       empty,
    output logic       full
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] rd_q, rd_d;
    logic [AW-1:0] wp_q, wp_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push;
    logic          do_pop;

    // Count reaches DEPTH only when its MSB is set.
    assign empty = (cnt_q == '0);
    assign full  = cnt_q[AW];
    assign dout  = mem_q[rd_q];

    // A pop frees a slot in the same cycle, so push is taken when full.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        rd_d  = rd_q + AW'(do_pop);
        wp_d  = wp_q + AW'(do_push);
        cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q  <= '0;
            wp_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wp_q  <= wp_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wp_q] <= din;
    end

endmodule

// File: rtl/kbd_mem_arbiter.sv
// Shares the memory port between the core and keyboard characters.
// Ports: clk, rst_n, bus (core req/gnt + mem port), io_char(_valid),
// wr_ptr, fifo_full, overflow, enter_pulse.
module kbd_mem_arbiter
    import kbd_pkg::*;
#(
    parameter logic [14:0] BUF_BASE   = DEF_BUF_BASE,
    parameter logic [14:0] BUF_END    = DEF_BUF_END,
    parameter int          FIFO_DEPTH = 4,
    parameter int          MAX_WAIT   = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    kbd_mem_arbiter_if.slave    bus,
    input  logic [7:0]          io_char,
    input  logic                io_char_valid,
    output logic [14:0]         wr_ptr,
    output logic                fifo_full,
    output logic                overflow,
    output logic                enter_pulse
);

    localparam int WW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [WW-1:0] WAIT_LAST = WW'(MAX_WAIT - 1);

    state_e        state_q, state_d;
    logic [WW-1:0] wait_q, wait_d;
    logic [14:0]   ptr_q, ptr_d;
    logic          ovf_q, ovf_d;
    logic [7:0]    head;
    logic          empty;
    logic          full;
    logic          pop;
    logic          mem_we_raw;

    assign pop = (state_q == S_IO);

    char_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (io_char_valid),
        .din   (io_char),
        .pop   (pop),
        .dout  (head),
        .empty (empty),
        .full  (full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_CORE;
            wait_q  <= '0;
            ptr_q   <= BUF_BASE;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            ptr_q   <= ptr_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = S_CORE;
        unique case (state_q)
            S_CORE: begin
                if (!empty && (!bus.core_req || wait_q == WAIT_LAST || full))
                    state_d = S_IO;
            end
            S_IO: state_d = S_CORE;
        endcase

        // Counts only cycles where a queued char loses to the core.
        wait_d = wait_q;
        if (empty || state_q == S_IO || state_d == S_IO)
            wait_d = '0;
        else if (bus.core_req && wait_q != WAIT_LAST)
            wait_d = wait_q + WW'(1);

        ptr_d = pop ? buf_next(ptr_q, BUF_BASE, BUF_END) : ptr_q;
        ovf_d = ovf_q | (io_char_valid & full & ~pop);
    end

    always_comb begin
        bus.core_gnt  = 1'b1;
        bus.mem_addr  = bus.core_addr;
        bus.mem_wdata = bus.core_wdata;
        mem_we_raw    = bus.core_we & bus.core_req;
        enter_pulse   = 1'b0;
        unique case (state_q)
            S_CORE: ;
            S_IO: begin
                bus.core_gnt  = 1'b0;
                bus.mem_addr  = ptr_q;
                bus.mem_wdata = {8'h00, head};
                mem_we_raw    = 1'b1;
                enter_pulse   = (head == CHAR_ENTER);
            end
        endcase
        // No stray write may reach memory while reset is held.
        bus.mem_we = rst_n & mem_we_raw;
    end

    assign wr_ptr    = ptr_q;
    assign fifo_full = full;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_kbd_mem_arbiter.sv
// Self-checking bench for kbd_mem_arbiter: cycle table plus
// hand-written busy-core, overflow, reset and wrap sequences.
module tb_kbd_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  io_char;
    logic        io_char_valid;
    logic [14:0] wr_ptr;
    logic        fifo_full;
    logic        overflow;
    logic        enter_pulse;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    kbd_mem_arbiter_if bus ();

    kbd_mem_arbiter dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus.slave),
        .io_char       (io_char),
        .io_char_valid (io_char_valid),
        .wr_ptr        (wr_ptr),
        .fifo_full     (fifo_full),
        .overflow      (overflow),
        .enter_pulse   (enter_pulse)
    );

    typedef struct {
        logic        req;
        logic [14:0] addr;
        logic [15:0] wd;
        logic        we;
        logic        v;
        logic [7:0]  ch;
        logic        gnt;
        logic [14:0] maddr;
        logic [15:0] mwd;
        logic        mwe;
        logic [14:0] ptr;
        logic        full;
        logic        ovf;
        logic        ent;
    } vec_t;

    vec_t tbl [15];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic req, input logic [14:0] a,
                         input logic [15:0] d, input logic we,
                         input logic v, input logic [7:0] c);
        bus.core_req   = req;
        bus.core_addr  = a;
        bus.core_wdata = d;
        bus.core_we    = we;
        io_char_valid  = v;
        io_char        = c;
    endtask

    function automatic logic [14:0] nxt(input logic [14:0] p);
        return (p == 15'h23FF) ? 15'h0605 : p + 15'd1;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [14:0] exp_ptr;
        logic [7:0]  wd_q [$];
        logic [14:0] wa_q [$];
        logic [7:0]  exp_c [5];
        logic [7:0]  ch;
        int n, got, steals, first, bad, tmo;

        tbl[0]  = '{0,15'h1234,16'hBEEF,1,0,8'h00, 1,15'h1234,16'hBEEF,0,15'h0605,0,0,0};
        tbl[1]  = '{1,15'h0010,16'h0055,1,1,8'h41, 1,15'h0010,16'h0055,1,15'h0605,0,0,0};
        tbl[2]  = '{0,15'h1234,16'hBEEF,0,0,8'h00, 1,15'h1234,16'hBEEF,0,15'h0605,0,0,0};
        tbl[3]  = '{1,15'h0100,16'h1111,1,0,8'h00, 0,15'h0605,16'h0041,1,15'h0605,0,0,0};
        tbl[4]  = '{1,15'h0100,16'h1111,1,0,8'h00, 1,15'h0100,16'h1111,1,15'h0606,0,0,0};
        tbl[5]  = '{0,15'h0000,16'h0000,0,1,8'h0D, 1,15'h0000,16'h0000,0,15'h0606,0,0,0};
        tbl[6]  = '{0,15'h0000,16'h0000,0,0,8'h00, 1,15'h0000,16'h0000,0,15'h0606,0,0,0};
        tbl[7]  = '{0,15'h0000,16'h0000,0,0,8'h00, 0,15'h0606,16'h000D,1,15'h0606,0,0,1};
        tbl[8]  = '{0,15'h0000,16'h0000,0,0,8'h00, 1,15'h0000,16'h0000,0,15'h0607,0,0,0};
        tbl[9]  = '{0,15'h0000,16'h0000,0,1,8'h42, 1,15'h0000,16'h0000,0,15'h0607,0,0,0};
        tbl[10] = '{0,15'h0000,16'h0000,0,1,8'h43, 1,15'h0000,16'h0000,0,15'h0607,0,0,0};
        tbl[11] = '{0,15'h0000,16'h0000,0,0,8'h00, 0,15'h0607,16'h0042,1,15'h0607,0,0,0};
        tbl[12] = '{0,15'h0000,16'h0000,0,0,8'h00, 1,15'h0000,16'h0000,0,15'h0608,0,0,0};
        tbl[13] = '{0,15'h0000,16'h0000,0,0,8'h00, 0,15'h0608,16'h0043,1,15'h0608,0,0,0};
        tbl[14] = '{0,15'h0000,16'h0000,0,0,8'h00, 1,15'h0000,16'h0000,0,15'h0609,0,0,0};

        // Reset state, with the core trying to write.
        rst_n = 1'b0;
        drive(1'b1, 15'h7FFF, 16'hFFFF, 1'b1, 1'b0, 8'h00);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_mem_we", 32'(bus.mem_we), 0);
        chk("rst_gnt", 32'(bus.core_gnt), 1);
        chk("rst_wr_ptr", 32'(wr_ptr), 32'h0605);
        chk("rst_full", 32'(fifo_full), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_enter", 32'(enter_pulse), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Cycle table.
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            drive(tbl[i].req, tbl[i].addr, tbl[i].wd, tbl[i].we,
                  tbl[i].v, tbl[i].ch);
            #1;
            chk($sformatf("t%0d_gnt", i), 32'(bus.core_gnt), 32'(tbl[i].gnt));
            chk($sformatf("t%0d_addr", i), 32'(bus.mem_addr), 32'(tbl[i].maddr));
            chk($sformatf("t%0d_wdata", i), 32'(bus.mem_wdata), 32'(tbl[i].mwd));
            chk($sformatf("t%0d_we", i), 32'(bus.mem_we), 32'(tbl[i].mwe));
            chk($sformatf("t%0d_ptr", i), 32'(wr_ptr), 32'(tbl[i].ptr));
            chk($sformatf("t%0d_full", i), 32'(fifo_full), 32'(tbl[i].full));
            chk($sformatf("t%0d_ovf", i), 32'(overflow), 32'(tbl[i].ovf));
            chk($sformatf("t%0d_enter", i), 32'(enter_pulse), 32'(tbl[i].ent));
        end
        exp_ptr = 15'h0609;

        // Busy core, one char: eight granted cycles, then one steal.
        @(negedge clk);
        drive(1'b1, 15'h0200, 16'h2222, 1'b1, 1'b1, 8'h5A);
        n = 0;
        got = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            drive(1'b1, 15'h0200, 16'h2222, 1'b1, 1'b0, 8'h00);
            #1;
            if (bus.core_gnt) n++;
            else begin
                got = 1;
                break;
            end
        end
        chk("busy_gnt_cycles", 32'(n), 8);
        chk("busy_steal_seen", 32'(got), 1);
        chk("busy_steal_addr", 32'(bus.mem_addr), 32'(exp_ptr));
        chk("busy_steal_data", 32'(bus.mem_wdata), 32'h005A);
        chk("busy_steal_we", 32'(bus.mem_we), 1);
        exp_ptr = nxt(exp_ptr);
        steals = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            drive(1'b1, 15'h0200, 16'h2222, 1'b1, 1'b0, 8'h00);
            #1;
            if (!bus.core_gnt) steals++;
        end
        chk("busy_no_extra_steal", 32'(steals), 0);
        chk("busy_wr_ptr", 32'(wr_ptr), 32'(exp_ptr));
        chk("busy_full", 32'(fifo_full), 0);

        // Busy core, six back-to-back chars into a depth-4 FIFO.
        exp_c = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h66};
        first = -1;
        bad = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            ch = 8'(8'h61 + i);
            drive(1'b1, 15'h0300, 16'h3333, 1'b0, i < 6, ch);
            #1;
            if (i == 4) chk("ovf_full_at_4", 32'(fifo_full), 1);
            if (bus.mem_we !== !bus.core_gnt) bad++;
            if (!bus.core_gnt) begin
                if (first < 0) first = i;
                wd_q.push_back(bus.mem_wdata[7:0]);
                wa_q.push_back(bus.mem_addr);
            end
        end
        chk("ovf_first_steal", 32'(first), 5);
        chk("ovf_we_only_steal", 32'(bad), 0);
        chk("ovf_write_count", 32'(wd_q.size()), 5);
        for (int j = 0; j < 5; j++) begin
            if (j < wd_q.size()) begin
                chk($sformatf("ovf_char%0d", j), 32'(wd_q[j]), 32'(exp_c[j]));
                chk($sformatf("ovf_addr%0d", j), 32'(wa_q[j]), 32'(exp_ptr));
            end
            exp_ptr = nxt(exp_ptr);
        end
        chk("ovf_sticky", 32'(overflow), 1);
        chk("ovf_wr_ptr", 32'(wr_ptr), 32'(exp_ptr));

        // Reset while a steal is in progress with two chars queued.
        @(negedge clk);
        drive(1'b1, 15'h0400, 16'h4444, 1'b1, 1'b1, 8'h71);
        @(negedge clk);
        drive(1'b1, 15'h0400, 16'h4444, 1'b1, 1'b1, 8'h72);
        got = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            drive(1'b1, 15'h0400, 16'h4444, 1'b1, 1'b0, 8'h00);
            #1;
            if (!bus.core_gnt) begin
                got = 1;
                break;
            end
        end
        chk("mrst_steal_seen", 32'(got), 1);
        rst_n = 1'b0;
        #1;
        chk("mrst_mem_we", 32'(bus.mem_we), 0);
        chk("mrst_wr_ptr", 32'(wr_ptr), 32'h0605);
        chk("mrst_full", 32'(fifo_full), 0);
        chk("mrst_ovf", 32'(overflow), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 15'h0000, 16'h0000, 1'b0, 1'b0, 8'h00);
        #1;
        chk("mrst_gnt_after", 32'(bus.core_gnt), 1);
        steals = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            #1;
            if (!bus.core_gnt || bus.mem_we) steals++;
        end
        chk("mrst_fifo_empty", 32'(steals), 0);

        // Fill the buffer up to its last address, then wrap.
        tmo = 0;
        for (int k = 0; k < 7674; k++) begin
            @(negedge clk);
            drive(1'b0, 15'h0000, 16'h0000, 1'b0, 1'b1, 8'h20);
            got = 0;
            for (int t = 0; t < 5; t++) begin
                @(negedge clk);
                drive(1'b0, 15'h0000, 16'h0000, 1'b0, 1'b0, 8'h00);
                #1;
                if (!bus.core_gnt) begin
                    got = 1;
                    break;
                end
            end
            if (!got) tmo++;
        end
        chk("wrap_fill_timeouts", 32'(tmo), 0);
        @(negedge clk);
        #1;
        chk("wrap_ptr_end", 32'(wr_ptr), 32'h23FF);
        wd_q.delete();
        wa_q.delete();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            ch = (i == 0) ? 8'h31 : 8'h32;
            drive(1'b0, 15'h0000, 16'h0000, 1'b0, i < 2, ch);
            #1;
            if (!bus.core_gnt) begin
                wd_q.push_back(bus.mem_wdata[7:0]);
                wa_q.push_back(bus.mem_addr);
            end
        end
        chk("wrap_count", 32'(wd_q.size()), 2);
        if (wd_q.size() == 2) begin
            chk("wrap_addr0", 32'(wa_q[0]), 32'h23FF);
            chk("wrap_data0", 32'(wd_q[0]), 32'h31);
            chk("wrap_addr1", 32'(wa_q[1]), 32'h0605);
            chk("wrap_data1", 32'(wd_q[1]), 32'h32);
        end
        chk("wrap_ptr_final", 32'(wr_ptr), 32'h0606);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
